conversor_bcd_binario: RTL and testbench
========================================

// Module: conversor_bcd_binario
// PURPOSE
//  Sequential decimal-entry converter: takes N_DIG packed BCD digits plus a sign flag, produces a
//  two's-complement binary value by iterative reverse double-dabble (shift right, subtract 3).
//  Inverse path of the binary->decimal (/10, %10) split feeding the HEX displays.
//  Sits between switch/keypad digit entry and the 4-bit adder/subtractor datapath.
//  Start/busy/done handshake; one conversion in flight.
// PARAMETERS
//  N_DIG  2  number of BCD digits on DIG (digit 0 = units, in DIG[3:0])
//  BIN_W  7  magnitude width; must satisfy 2**BIN_W > 10**N_DIG - 1
// PORTS
//  CLOCK_50  in   1              system clock, rising edge
//  RST       in   1              asynchronous reset, active-high
//  START     in   1              request; sampled only in IDLE
//  DIG       in   4*N_DIG        packed BCD input, sampled at accept edge
//  NEG       in   1              1 = negate result, sampled at accept edge
//  BUSY      out  1              high in CONV
//  DONE      out  1              one-cycle pulse, RES/ERR valid
//  ERR       out  1              invalid BCD digit (>9) in accepted request
//  RES       out  BIN_W+1        two's-complement result, held until next accept
// BEHAVIOUR
//  - Interface: single clock CLOCK_50; RST asynchronous, active-high. RST forces state IDLE,
//    BUSY=0, DONE=0, ERR=0, RES=0, shift register and counter=0. Release mid-conversion: the
//    aborted request is lost, no DONE.
//  - States: IDLE, CONV, FIM (2-bit encoding).
//  - IDLE: START=1 at edge k -> accept: load SR = {DIG, BIN_W'b0}, latch NEG, cnt=0.
//    If any digit > 9: go to FIM, ERR=1, RES=0 (DONE in cycle after edge k).
//    Else go to CONV, ERR=0.
//  - CONV: each edge: SR >>= 1 (zero in at MSB), then for every BCD digit field d>=8: d-=3;
//    cnt++. The edge performing shift number BIN_W loads RES and enters FIM.
//    Valid-input latency: DONE high in the cycle after edge k+BIN_W (7 cycles default).
//  - RES = NEG ? -{1'b0,mag} : {1'b0,mag}, mag = low BIN_W bits of SR after final shift.
//    -0 yields 0. BCD field of SR is zero at end for valid input (internal assertion).
//  - FIM: DONE=1 for exactly one cycle, then IDLE. START during FIM is ignored.
//  - START while BUSY: ignored, no queueing; DIG/NEG changes after accept have no effect.
//  - Back-to-back: START held high re-accepts on the first IDLE edge after FIM.
//  - RES and ERR change only at accept(error)/final-shift edges; stable otherwise.
// STRUCTURE
//  - Shared header bcd_defs.vh: state codes (S_IDLE, S_CONV, S_FIM), BCD_MAX=9,
//    correction constants (limit 8, subtract 3), counter width macro.
//  - Sub-module corretor_digito: 4-bit combinational d>=8 ? d-3 : d; instantiated N_DIG
//    times via generate. Top holds FSM, counter, SR, sign/negation and output regs.
// TESTING
//  - DIG=8'h99, NEG=0, START pulse -> BUSY 7 cycles, DONE pulse, RES=8'h63, ERR=0.
//  - DIG=8'h10, NEG=1 -> RES=8'hF6 (-10); DIG=8'h00, NEG=1 -> RES=8'h00.
//  - DIG=8'h1A -> DONE in cycle after accept, ERR=1, RES=0; next valid 8'h05 -> ERR=0, RES=5.
//  - START pulsed and DIG changed to 8'h42 mid-CONV of 8'h37 -> single DONE, RES=8'h25.
//  - RST asserted mid-CONV (cycle 3) -> all outputs 0 immediately, no DONE; next 8'h12 -> 8'h0C.
//  - START held high, DIG=8'h07 -> DONE every 9 cycles (accept, 7 shifts, FIM), RES=7 each.

Source files
------------

// File: rtl/conversor_bcd_binario_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state codes,
// BCD validity limit, reverse double-dabble correction constants and the
// helper that sizes the shift counter.
package conversor_bcd_binario_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CONV = 2'b01,
        S_FIM  = 2'b10
    } state_t;

    // Largest legal BCD digit value.
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // After each right shift, a digit field holding 8 or more carried a
    // half-weight ten from the digit above; subtracting 3 restores it.
    localparam logic [3:0] CORR_LIMIT = 4'd8;
    localparam logic [3:0] CORR_SUB   = 4'd3;

    // Counter must reach BIN_W-1 (index of the last shift) without wrap.
    function automatic int cnt_width(input int bin_w);
        return (bin_w < 2) ? 1 : $clog2(bin_w + 1);
    endfunction

endpackage : conversor_bcd_binario_pkg

// File: rtl/conversor_bcd_binario_corretor_digito.sv
// Single BCD digit correction step for reverse double-dabble:
// a field of 8 or more after the shift is reduced by 3.
module corretor_digito
    import conversor_bcd_binario_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= CORR_LIMIT) ? (i_dig - CORR_SUB) : i_dig;

endmodule : corretor_digito

// File: rtl/conversor_bcd_binario.sv
// Sequential BCD-to-binary converter. Accepts N_DIG packed BCD digits and a
// sign flag, shifts them right BIN_W times through a combined BCD/binary
// shift register with per-digit correction, and delivers a two's-complement
// result with a one-cycle DONE pulse. Invalid digits short-circuit to ERR.
module conversor_bcd_binario
    import conversor_bcd_binario_pkg::*;
#(
    parameter int N_DIG = 2,
    parameter int BIN_W = 7
)
(
    input  logic               CLOCK_50,
    input  logic               RST,
    input  logic               START,
    input  logic [4*N_DIG-1:0] DIG,
    input  logic               NEG,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [BIN_W:0]     RES
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t             r_state;
    state_t             w_state_next;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_err;
    logic [BIN_W:0]     r_res;

    logic [SR_W-1:0]    w_sr_shift;
    logic [SR_W-1:0]    w_sr_next;
    logic [N_DIG-1:0]   w_dig_bad;
    logic               w_dig_invalid;
    logic               w_last_shift;
    logic [BIN_W:0]     w_mag_ext;
    logic [BIN_W:0]     w_res_next;

    // Plain right shift; zero enters at the top of the BCD field.
    assign w_sr_shift = r_sr >> 1;

    // Per-digit validity check on the raw input and correction on the
    // shifted BCD field; the binary field passes through untouched.
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        assign w_dig_bad[gi] = (DIG[4*gi +: 4] > BCD_MAX);

        corretor_digito u_corr (
            .i_dig (w_sr_shift[BIN_W + 4*gi +: 4]),
            .o_dig (w_sr_next [BIN_W + 4*gi +: 4])
        );
    end

    assign w_sr_next[BIN_W-1:0] = w_sr_shift[BIN_W-1:0];
    assign w_dig_invalid        = |w_dig_bad;
    assign w_last_shift         = (r_cnt == CNT_W'(BIN_W - 1));

    // Magnitude after the final shift, optionally negated; -0 stays 0.
    assign w_mag_ext  = {1'b0, w_sr_next[BIN_W-1:0]};
    assign w_res_next = r_neg ? ((~w_mag_ext) + (BIN_W+1)'(1)) : w_mag_ext;

    // State register.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, fixed-length conversion, one-cycle FIM.
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_next = w_dig_invalid ? S_FIM : S_CONV;
                end
            end
            S_CONV: begin
                if (w_last_shift) begin
                    w_state_next = S_FIM;
                end
            end
            S_FIM:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift/correct in CONV, capture result on the
    // final shift. RES/ERR only move at error-accept or final-shift edges.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
            r_err <= 1'b0;
            r_res <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_sr  <= {DIG, BIN_W'(0)};
                        r_neg <= NEG;
                        r_cnt <= '0;
                        if (w_dig_invalid) begin
                            r_err <= 1'b1;
                            r_res <= '0;
                        end
                    end
                end
                S_CONV: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_shift) begin
                        r_res <= w_res_next;
                        r_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY = (r_state == S_CONV);
    assign DONE = (r_state == S_FIM);
    assign ERR  = r_err;
    assign RES  = r_res;

    // A valid conversion must drain the BCD field completely.
    a_bcd_drained: assert property (
        @(posedge CLOCK_50) disable iff (RST)
        (r_state == S_CONV && w_last_shift) |-> (w_sr_next[SR_W-1:BIN_W] == '0)
    );

endmodule : conversor_bcd_binario

// File: tb/tb_conversor_bcd_binario.sv
// Self-checking bench for conversor_bcd_binario (N_DIG=2, BIN_W=7).
module tb_conversor_bcd_binario;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dig;
    logic       neg;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] res;

    int n_checks = 0;
    int n_errors = 0;

    conversor_bcd_binario #(.N_DIG(2), .BIN_W(7)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .START    (start),
        .DIG      (dig),
        .NEG      (neg),
        .BUSY     (busy),
        .DONE     (done),
        .ERR      (err),
        .RES      (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: decimal value from the digits, signed, wrapped to 8 bits.
    function automatic void model(input logic [7:0] d, input logic n,
                                  output logic [7:0] e_res, output logic e_err,
                                  output int e_lat, output int e_busy);
        int t;
        int u;
        int v;
        t = int'(d[7:4]);
        u = int'(d[3:0]);
        if (t > 9 || u > 9) begin
            e_err  = 1'b1;
            e_res  = 8'h00;
            e_lat  = 1;
            e_busy = 0;
        end else begin
            v = t * 10 + u;
            if (n) v = -v;
            e_res  = 8'(v);
            e_err  = 1'b0;
            e_lat  = 8;
            e_busy = 7;
        end
    endfunction

    // One request from IDLE; reports DONE latency (cycles after accept edge),
    // BUSY cycle count, captured outputs, and DONE one cycle later.
    task automatic do_conv(input logic [7:0] d, input logic n,
                           output logic [7:0] o_res, output logic o_err,
                           output int lat, output int busy_n, output logic done_after);
        lat        = 0;
        busy_n     = 0;
        o_res      = 8'hxx;
        o_err      = 1'bx;
        done_after = 1'bx;
        @(negedge clk);
        dig   = d;
        neg   = n;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                dig   = 8'($urandom);
                neg   = 1'($urandom);
            end
            if (busy) busy_n++;
            if (done) begin
                lat   = c;
                o_res = res;
                o_err = err;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       n;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] g_res;
        logic       g_err;
        int         g_lat;
        int         g_busy;
        logic       g_done_after;
        logic [7:0] e_res;
        logic       e_err;
        int         e_lat;
        int         e_busy;
        int         done_n;
        int         done_at[$];
        logic [7:0] res_at[$];

        vecs[0] = '{8'h99, 1'b0, 8'h63, 1'b0, 8};
        vecs[1] = '{8'h10, 1'b1, 8'hF6, 1'b0, 8};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0, 8};
        vecs[3] = '{8'h1A, 1'b0, 8'h00, 1'b1, 1};
        vecs[4] = '{8'h05, 1'b0, 8'h05, 1'b0, 8};
        vecs[5] = '{8'h80, 1'b1, 8'hB0, 1'b0, 8};
        vecs[6] = '{8'hA0, 1'b1, 8'h00, 1'b1, 1};
        vecs[7] = '{8'h99, 1'b1, 8'h9D, 1'b0, 8};

        rst   = 1'b1;
        start = 1'b0;
        dig   = 8'h00;
        neg   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err",  32'(err),  32'h0);
        check("reset_res",  32'(res),  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_conv(vecs[i].d, vecs[i].n, g_res, g_err, g_lat, g_busy, g_done_after);
            check($sformatf("vec%0d_res", i), 32'(g_res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), 32'(g_busy), (vecs[i].exp_lat == 8) ? 32'd7 : 32'd0);
            check($sformatf("vec%0d_done_pulse", i), 32'(g_done_after), 32'h0);
        end

        // Random requests against the decimal reference.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            logic       rn;
            rd = 8'($urandom);
            rn = 1'($urandom);
            model(rd, rn, e_res, e_err, e_lat, e_busy);
            do_conv(rd, rn, g_res, g_err, g_lat, g_busy, g_done_after);
            check($sformatf("rnd%0d_res_%02h", i, rd), 32'(g_res), 32'(e_res));
            check($sformatf("rnd%0d_err_%02h", i, rd), 32'(g_err), 32'(e_err));
            check($sformatf("rnd%0d_lat_%02h", i, rd), 32'(g_lat), 32'(e_lat));
            check($sformatf("rnd%0d_busy_%02h", i, rd), 32'(g_busy), 32'(e_busy));
        end

        // START and DIG changes during CONV are ignored.
        @(negedge clk);
        dig   = 8'h37;
        neg   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dig   = 8'h42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_n = 0;
        g_res  = 8'hxx;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                g_res = res;
            end
        end
        check("midconv_done_count", 32'(done_n), 32'd1);
        check("midconv_res", 32'(g_res), 32'h25);

        // Reset in the middle of a conversion.
        @(negedge clk);
        dig   = 8'h55;
        neg   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prerst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err",  32'(err),  32'h0);
        check("rst_res",  32'(res),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("rst_no_done", 32'(done_n), 32'd0);
        do_conv(8'h12, 1'b0, g_res, g_err, g_lat, g_busy, g_done_after);
        check("postrst_res", 32'(g_res), 32'h0C);
        check("postrst_lat", 32'(g_lat), 32'd8);

        // START held high: back-to-back accepts every 9 cycles.
        @(negedge clk);
        dig   = 8'h07;
        neg   = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(c);
                res_at.push_back(res);
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(done_at.size()), 32'd3);
        for (int i = 0; i < done_at.size(); i++) begin
            check($sformatf("held_res%0d", i), 32'(res_at[i]), 32'h07);
            if (i > 0)
                check($sformatf("held_period%0d", i), 32'(done_at[i] - done_at[i-1]), 32'd9);
        end
        repeat (12) @(negedge clk);
        check("final_idle_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_conversor_bcd_binario
